clk_div_cfg_sequencer: RTL and testbench

//   Shares one clock_divider_counter configuration port between NUM_REQ requesters.

---
 rtl/clk_div_cfg_sequencer_pkg.sv | 24 ++
 rtl/clk_div_cfg_sequencer_if.sv | 26 ++
 rtl/clk_div_cfg_sequencer_rr_arb.sv | 31 +++
 rtl/clk_div_cfg_sequencer.sv | 111 +++++++++++
 tb/tb_clk_div_cfg_sequencer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/clk_div_cfg_sequencer_pkg.sv
// Shared types and helpers for the clock-divider configuration sequencer.
package clk_div_cfg_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, ACK} clk_div_cfg_state_e;

    localparam int DIV_W = 8;
    localparam int CNT_W = 9;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Settle time is two periods of the divided clock, never shorter than settle_min.
    // Bypass ratios 0 and 1 always fall back to settle_min.
    function automatic logic [CNT_W-1:0] settle_len(input logic [DIV_W-1:0] div,
                                                    input int settle_min);
        logic [CNT_W-1:0] twice;
        logic [CNT_W-1:0] floor_len;
        twice     = {div, 1'b0};
        floor_len = CNT_W'(settle_min);
        return (twice > floor_len) ? twice : floor_len;
    endfunction

endpackage

// File: rtl/clk_div_cfg_sequencer_if.sv
// Requester-facing bus of the sequencer plus the divider configuration outputs.
interface clk_div_cfg_sequencer_if
    import clk_div_cfg_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*DIV_W-1:0] div_i;
    logic [NUM_REQ-1:0]       ack_o;
    logic                     busy_o;
    logic [DIV_W-1:0]         cur_div_o;
    logic [DIV_W-1:0]         clk_div_o;
    logic                     clk_div_valid_o;

    modport master (
        output req_i, div_i,
        input  ack_o, busy_o, cur_div_o, clk_div_o, clk_div_valid_o
    );

    modport slave (
        input  req_i, div_i,
        output ack_o, busy_o, cur_div_o, clk_div_o, clk_div_valid_o
    );

endinterface

// File: rtl/clk_div_cfg_sequencer_rr_arb.sv
// Combinational round-robin picker: first active request at or after ptr wins.
module clk_div_cfg_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    // NOTE: every output gets a default before the loop, so no path leaves a latch.
    always_comb begin
        int j;
        valid  = 1'b0;
        winner = '0;
        j      = 0;
        // Walk from the farthest offset down so the nearest active request wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            for (int m = 0; m < NUM_REQ; m++) begin
                if (m == j && req[m]) begin
                    valid  = 1'b1;
                    winner = IDX_W'(m);
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_cfg_sequencer.sv
// Arbitrates requesters onto one divider config port, pulses the new ratio,
// waits for the divided clock to settle, then acks the winning requester.
module clk_div_cfg_sequencer
    import clk_div_cfg_pkg::*;
#(
    parameter int               NUM_REQ    = 4,
    parameter int               SETTLE_MIN = 16,
    parameter logic [DIV_W-1:0] DIV_INIT   = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    clk_div_cfg_sequencer_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    clk_div_cfg_state_e state, state_next;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic [DIV_W-1:0] win_div;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] clk_div;
    logic             clk_div_valid;
    logic             busy;
    logic [NUM_REQ-1:0] ack;

    clk_div_cfg_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (bus.req_i),
        .ptr    (ptr),
        .valid  (win_valid),
        .winner (win_idx)
    );

    always_comb begin
        win_div = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IDX_W'(k)) win_div = bus.div_i[k*DIV_W +: DIV_W];
        end
    end

    // NOTE: synchronous reset lives inside the clocked block; nothing here is a RAM.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (win_valid) state_next = (win_div == cur_div) ? ACK : LOAD;
            LOAD:    state_next = SETTLE;
            SETTLE:  if (cnt <= CNT_W'(1)) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            idx           <= '0;
            div_q         <= DIV_INIT;
            cnt           <= '0;
            cur_div       <= DIV_INIT;
            clk_div       <= DIV_INIT;
            clk_div_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Registered outputs follow the next state so they line up with it.
            clk_div_valid <= (state_next == LOAD);
            busy          <= (state_next != IDLE);

            if (state == IDLE && win_valid) begin
                idx   <= win_idx;
                div_q <= win_div;
                ptr   <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                if (state_next == LOAD) clk_div <= win_div;
            end

            if (state == LOAD) begin
                cur_div <= div_q;
                cnt     <= settle_len(div_q, SETTLE_MIN);
            end else if (state == SETTLE) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        ack = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ack[k] = (state == ACK) && (idx == IDX_W'(k));
        end
    end

    assign bus.ack_o           = ack;
    assign bus.busy_o          = busy;
    assign bus.cur_div_o       = cur_div;
    assign bus.clk_div_o       = clk_div;
    assign bus.clk_div_valid_o = clk_div_valid;

endmodule

// File: tb/tb_clk_div_cfg_sequencer.sv
// Directed bench: hand-computed pulse/ack cycles for arbitration, settle, skip and reset.
module tb_clk_div_cfg_sequencer;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    clk_div_cfg_sequencer_if #(.NUM_REQ(4)) bus ();

    clk_div_cfg_sequencer #(
        .NUM_REQ    (4),
        .SETTLE_MIN (16),
        .DIV_INIT   (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [7:0] d);
        bus.div_i[r*8 +: 8] = d;
        bus.req_i[r]        = 1'b1;
    endtask

    // Cycle 0 is the current IDLE cycle; cycle n is sampled 1 time unit after the n-th edge.
    task automatic serve(input string tag, input int exp_idx, input logic [7:0] exp_div,
                         input bit exp_pulse, input int exp_ack, input bit drop);
        int         valid_cnt = 0;
        int         valid_at  = -1;
        int         ack_at    = -1;
        int         busy_cnt  = 0;
        logic [7:0] pulse_div = '0;
        logic [3:0] ack_vec   = '0;
        logic [3:0] want_ack;
        want_ack = 4'b0001 << exp_idx;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            step();
            if (bus.busy_o) busy_cnt++;
            if (bus.clk_div_valid_o) begin
                valid_cnt++;
                valid_at  = cyc;
                pulse_div = bus.clk_div_o;
            end
            if (bus.ack_o != 4'b0000) begin
                ack_at  = cyc;
                ack_vec = bus.ack_o;
                break;
            end
        end
        check({tag, ".ack_cycle"}, ack_at, exp_ack);
        check({tag, ".ack_vec"}, ack_vec, want_ack);
        check({tag, ".pulses"}, valid_cnt, exp_pulse ? 1 : 0);
        if (exp_pulse) begin
            check({tag, ".pulse_cycle"}, valid_at, 1);
            check({tag, ".pulse_div"}, pulse_div, exp_div);
        end
        check({tag, ".busy_cycles"}, busy_cnt, exp_ack);
        if (drop) bus.req_i[exp_idx] = 1'b0;
        step();
        check({tag, ".ack_one_cycle"}, bus.ack_o, 4'b0000);
        check({tag, ".idle_busy"}, bus.busy_o, 1'b0);
        check({tag, ".cur_div"}, bus.cur_div_o, exp_div);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.req_i  = '0;
        bus.div_i  = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.req_i = '0;
        bus.div_i = '0;
        do_reset();

        check("reset.busy", bus.busy_o, 1'b0);
        check("reset.valid", bus.clk_div_valid_o, 1'b0);
        check("reset.ack", bus.ack_o, 4'b0000);
        check("reset.clk_div", bus.clk_div_o, 8'h00);
        check("reset.cur_div", bus.cur_div_o, 8'h00);

        // div 4: 2*4=8 < 16, so settle=16 and ack at 2+16.
        set_req(0, 8'd4);
        serve("t1", 0, 8'd4, 1'b1, 18, 1'b1);

        // div 20: settle=40, ack at 42 (41 after the pulse).
        set_req(2, 8'd20);
        serve("t2", 2, 8'd20, 1'b1, 42, 1'b1);

        // All four requesting from reset; grant order 0,1,2,3,0.
        do_reset();
        set_req(0, 8'd10);
        set_req(1, 8'd3);
        set_req(2, 8'd30);
        set_req(3, 8'd9);
        serve("t3.g0", 0, 8'd10, 1'b1, 22, 1'b0);
        serve("t3.g1", 1, 8'd3,  1'b1, 18, 1'b0);
        serve("t3.g2", 2, 8'd30, 1'b1, 62, 1'b0);
        serve("t3.g3", 3, 8'd9,  1'b1, 20, 1'b0);
        serve("t3.g4", 0, 8'd10, 1'b1, 22, 1'b0);
        bus.req_i = '0;

        // Same value as cur_div (10): skip, no pulse, ack at cycle 1.
        set_req(1, 8'd10);
        serve("t4", 1, 8'd10, 1'b0, 1, 1'b1);

        // Bypass ratios use SETTLE_MIN.
        set_req(2, 8'd1);
        serve("t5.div1", 2, 8'd1, 1'b1, 18, 1'b1);
        set_req(2, 8'd0);
        serve("t5.div0", 2, 8'd0, 1'b1, 18, 1'b1);

        // Largest ratio: settle=510, ack at 512.
        set_req(3, 8'hFF);
        serve("t5.div255", 3, 8'hFF, 1'b1, 512, 1'b1);

        // Reset during SETTLE of a div-50 request (settle=100).
        set_req(1, 8'd50);
        repeat (6) step();
        check("t6.in_settle_busy", bus.busy_o, 1'b1);
        rst = 1'b1;
        step();
        check("t6.rst_busy", bus.busy_o, 1'b0);
        check("t6.rst_ack", bus.ack_o, 4'b0000);
        check("t6.rst_valid", bus.clk_div_valid_o, 1'b0);
        check("t6.rst_cur_div", bus.cur_div_o, 8'h00);
        check("t6.rst_clk_div", bus.clk_div_o, 8'h00);
        rst = 1'b0;
        serve("t6.afresh", 1, 8'd50, 1'b1, 102, 1'b0);
        // Held past its ack with the same div: re-arbitrated onto the skip path.
        serve("t6.rearb", 1, 8'd50, 1'b0, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
